// File: rtl/sudoku_display_driver_if.sv
// Bundles the controller-facing row/cursor inputs and the board display pins
// of the Sudoku display driver so both ends share one connection point.
interface sudoku_display_driver_if;
  logic [15:0] currentRow;
  logic [3:0]  currentNum;
  logic [1:0]  rowSel;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [3:0]  rowLed;

  // The controller side drives cell data; the display driver drives the pins.
  modport master (
    output currentRow, currentNum, rowSel,
    input  seg, dp, an, rowLed
  );

  modport slave (
    input  currentRow, currentNum, rowSel,
    output seg, dp, an, rowLed
  );
endinterface

// File: rtl/sudoku_display_driver.sv
// Time-multiplexes one Sudoku row onto a 4-digit common-anode 7-segment display,
// blinks the cursor digit and lights a one-hot indicator for the current game row.
module sudoku_display_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic                    CLK,
  input  logic                    RST,
  sudoku_display_driver_if.slave  bus
);

  localparam int PRE_W = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int BC_W  = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BLINK_DIV - 1);

  logic [PRE_W-1:0] pre, preNext;
  logic [BC_W-1:0]  bc, bcNext;
  logic [1:0]       idx, idxNext;
  logic             blinkOff, blinkOffNext;
  logic             live, liveNext;
  logic [15:0]      shadowRow, shadowRowNext;
  logic [3:0]       shadowNum, shadowNumNext;
  logic             scanTick, blinkWrap, frameWrap;
  logic [3:0]       nibble;
  logic             cursorHere;

  logic [6:0] segReg, segNext;
  logic       dpReg, dpNext;
  logic [3:0] anReg, anNext;
  logic [3:0] rowLedReg;

  // Active-low glyphs; a zero nibble is an empty cell and stays dark.
  function automatic logic [6:0] hexGlyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'h7F;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  always_comb begin
    scanTick  = (pre == PRE_LAST);
    blinkWrap = (bc == BC_LAST);
    frameWrap = scanTick && (idx == 2'd3);

    preNext       = scanTick ? '0 : pre + 1'b1;
    idxNext       = scanTick ? idx + 2'd1 : idx;
    bcNext        = blinkWrap ? '0 : bc + 1'b1;
    blinkOffNext  = blinkOff ^ blinkWrap;
    liveNext      = live | scanTick;
    shadowRowNext = frameWrap ? bus.currentRow : shadowRow;
    shadowNumNext = frameWrap ? bus.currentNum : shadowNum;
  end

  // Display registers are loaded from next-state values so a new slot or blink
  // phase appears one cycle after the edge that produced it.
  always_comb begin
    nibble     = shadowRowNext[{idxNext, 2'b00} +: 4];
    cursorHere = shadowNumNext[idxNext];
    anNext     = 4'hF;
    segNext    = 7'h7F;
    dpNext     = 1'b1;
    if (liveNext) begin
      anNext  = ~(4'b0001 << idxNext);
      segNext = (cursorHere && blinkOffNext) ? 7'h7F : hexGlyph(nibble);
      dpNext  = ~cursorHere;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pre       <= '0;
      bc        <= '0;
      idx       <= 2'd3;
      blinkOff  <= 1'b0;
      live      <= 1'b0;
      shadowRow <= '0;
      shadowNum <= '0;
      anReg     <= 4'hF;
      segReg    <= 7'h7F;
      dpReg     <= 1'b1;
      rowLedReg <= 4'b0000;
    end else begin
      pre       <= preNext;
      bc        <= bcNext;
      idx       <= idxNext;
      blinkOff  <= blinkOffNext;
      live      <= liveNext;
      shadowRow <= shadowRowNext;
      shadowNum <= shadowNumNext;
      anReg     <= anNext;
      segReg    <= segNext;
      dpReg     <= dpNext;
      rowLedReg <= 4'b0001 << bus.rowSel;
    end
  end

  assign bus.an     = anReg;
  assign bus.seg    = segReg;
  assign bus.dp     = dpReg;
  assign bus.rowLed = rowLedReg;

endmodule

// File: doc/sudoku_display_driver.md
# sudoku_display_driver

Display-side consumer of the Sudoku interface controller's row/cursor outputs. Time-multiplexes the current 16-bit game row onto a 4-digit common-anode 7-segment display, blinks the cursor digit, and lights a one-hot row indicator. Sits between the interface controller (`currentRow`, `currentNum`, `RamAddr`) and the board's display pins.

## Interface
- `SCAN_DIV`, 50000: CLK cycles per digit slot. Must be ≥ 2.
- `BLINK_DIV`, 12500000: CLK cycles per blink half-period. Must be ≥ 2.

Ports:
- `CLK`  in  1  system clock.
- `RST`  in  1  reset, synchronous, active-high.
- `currentRow`  in  16  four cell values; digit i = `currentRow[4i+3:4i]`.
- `currentNum`  in  4  cursor select. Bit i set means digit i blinks. 0000 means no cursor.
- `rowSel`  in  2  current game row, driven from the controller's RAM address.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.
- `an`  out  4  digit enables, active-low; `an[i]` drives digit i.
- `rowLed`  out  4  one-hot row indicator, active-high.

## Operation
- Prescaler `pre` counts 0..SCAN_DIV-1 and wraps. `scanTick` is high for one cycle when `pre == SCAN_DIV-1`.
- Digit index `idx` (2 bits) advances on `scanTick` and wraps 3→0.
- Frame capture: on a `scanTick` that takes `idx` from 3 to 0, `currentRow` and `currentNum` are copied into shadow registers.
  - All four digits of a frame come from one snapshot; there is no tearing.
  - Input changes mid-frame are ignored until the next frame boundary.
- Blink:
  - Counter `bc` counts 0..BLINK_DIV-1.
  - At the wrap, `blinkOff` toggles.
  - `blinkOff = 0` means the cursor digit is shown; `blinkOff = 1` means it is blanked.
- Per-slot output for digit `d = idx`:
  - `an` = one-cold on bit d.
  - Nibble `v` comes from the shadow row.
  - `v = 0` is an empty cell: `seg = 7'h7F` (blank).
  - `v = 1..F`: standard hex glyphs. Examples: 1 → 7'h79, 2 → 7'h24, 3 → 7'h30, 4 → 7'h19, A → 7'h08, F → 7'h0E.
  - If shadow cursor bit d is set and `blinkOff = 1`, `seg` is forced to 7'h7F.
  - `dp` is low (lit) whenever shadow cursor bit d is set, regardless of blink phase. This keeps an empty cursor cell visible.
- `rowLed = 1 << rowSel`, registered every cycle. It does not depend on the scan.
- Reset (RST high at a CLK edge) sets:
  - `pre = 0`, `idx = 3`, `bc = 0`, `blinkOff = 0`, shadows = 0.
  - `an = 4'b1111`, `seg = 7'h7F`, `dp = 1`, `rowLed = 4'b0000`.
- Reset has priority over every other event, including a coincident `scanTick` or blink wrap.

## Timing
- `an`, `seg`, `dp` and `rowLed` are all registers; there are no combinational paths from input to output.
- First `scanTick` occurs SCAN_DIV cycles after reset deassertion.
  - It sets `idx` to 0 and captures the shadows.
  - Outputs show digit 0 from the following cycle.
  - Before that tick, outputs hold their reset values.
- Capture-to-display latency: `an`/`seg`/`dp` reflect a new slot 1 cycle after its `scanTick`.
- Input-to-display latency: inputs sampled at the frame-boundary edge appear on digit 0 one cycle later.
  - Worst case from an input change to display is 4·SCAN_DIV + 1 cycles.
- Each slot lasts exactly SCAN_DIV cycles; a full frame is 4·SCAN_DIV cycles.
- Blink period is 2·BLINK_DIV cycles.
  - A `blinkOff` toggle takes effect on `seg` the cycle after the toggle.
  - This applies mid-slot.
- `rowLed` latency is 1 cycle after `rowSel` changes.
- Simultaneous `scanTick` and blink wrap: both take effect on the same edge, and the outputs use the new `idx` and the new `blinkOff`.
- Counter widths:
  - `pre` must hold SCAN_DIV-1.
  - `bc` must hold BLINK_DIV-1.
  - No counter may overflow before its terminal compare.

## Test plan
All scenarios use SCAN_DIV=4 and BLINK_DIV=32.

- Reset: hold RST 3 cycles, then release.
  - Outputs: `an=1111`, `seg=7F`, `dp=1`, `rowLed=0000` for 4 cycles.
  - Cycle 5: `an=1110`.
- Scan order: `currentRow=16'h4321`, `currentNum=0`.
  - `an` steps 1110→1101→1011→0111, 4 cycles each.
  - `seg` shows 79, 24, 30, 19 in that order.
  - `dp=1` throughout.
- Blink and blank: `currentRow=16'h0302`, `currentNum=4'b0001`.
  - Digit 0 shows 24 with `dp=0` while `blinkOff=0`.
  - Digit 0 shows 7F with `dp=0` while `blinkOff=1`; toggling every 32 cycles.
  - Digits 1 and 3 show 7F with `dp=1`.
  - Digit 2 shows 30.
- Frame coherence: change `currentRow` from 16'h1111 to 16'h2222 while digit 1 is displayed.
  - Digits 2 and 3 still show 79.
  - The next digit 0 shows 24.
- Row indicator: `rowSel` steps 0→1→2→3→0.
  - `rowLed` = 0001, 0010, 0100, 1000, 0001, each one cycle after its `rowSel` change.
- Reset mid-frame: assert RST while digit 2 is active with `blinkOff=1`.
  - The next cycle shows reset values.
  - Restart follows the reset scenario, with `blinkOff=0`.
